// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: data-memory loads/stores over a req/ack bus, lane alignment,
// load extension, forwarding taps to EX and the writeback register.
module mem_access_stage #(
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_EX,
  input  logic [6:0]  opcode_EX,
  input  logic [2:0]  funct3_EX,
  input  logic [4:0]  rd_EX,
  input  logic [31:0] res_EX,
  input  logic [31:0] x2_EX,
  output logic        stall_MEM,
  output logic [4:0]  rd_MEM,
  output logic [31:0] res_MEM,
  output logic [4:0]  rd_WB,
  output logic [31:0] res_WB,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        misalign_err,
  output logic        bus_err
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_ACCESS = 1'b1} state_t;

  function automatic logic f_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      default: return (a != 2'b00);
    endcase
  endfunction

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_valid;
  logic [6:0]       r_opcode;
  logic [2:0]       r_funct3;
  logic [4:0]       r_rd;
  logic [31:0]      r_res;
  logic [31:0]      r_x2;

  logic        w_ex_access;
  logic        w_is_load;
  logic        w_is_store;
  logic        w_is_branch;
  logic        w_misaligned;
  logic        w_access;
  logic        w_last;
  logic        w_timeout;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic [4:0]  w_wb_rd;
  logic [31:0] w_wb_res;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;

  // Decide at capture time whether the incoming op will hold the bus, so that
  // dmem_req is a registered state bit valid from its first cycle in MEM.
  assign w_ex_access = valid_EX && (opcode_EX == OP_LOAD || opcode_EX == OP_STORE) &&
                       !f_misaligned(funct3_EX, res_EX[1:0]);

  assign w_is_load    = (r_opcode == OP_LOAD);
  assign w_is_store   = (r_opcode == OP_STORE);
  assign w_is_branch  = (r_opcode == OP_BRANCH);
  assign w_misaligned = r_valid && (w_is_load || w_is_store) &&
                        f_misaligned(r_funct3, r_res[1:0]);
  assign w_access     = (r_state == ST_ACCESS);
  assign w_last       = (r_cnt == LAST_CNT);
  assign w_timeout    = w_access && !dmem_ack && w_last;

  assign stall_MEM    = w_access && !dmem_ack && !w_last;
  assign dmem_req     = w_access;
  assign dmem_we      = w_access && w_is_store;
  assign dmem_addr    = w_access ? {r_res[31:2], 2'b00} : 32'h0;
  assign dmem_be      = w_be;
  assign dmem_wdata   = w_wdata;
  assign misalign_err = w_misaligned;
  assign bus_err      = w_timeout;

  assign rd_MEM  = (r_valid && !w_is_load && !w_is_store && !w_is_branch) ? r_rd : 5'd0;
  assign res_MEM = r_res;

  always_comb begin
    w_be    = 4'b0000;
    w_wdata = 32'h0;
    if (w_access) begin
      if (w_is_load) begin
        w_be = 4'b1111;
      end else begin
        case (r_funct3[1:0])
          2'b00: begin
            w_be    = 4'b0001 << r_res[1:0];
            w_wdata = {4{r_x2[7:0]}};
          end
          2'b01: begin
            w_be    = 4'b0011 << r_res[1:0];
            w_wdata = {2{r_x2[15:0]}};
          end
          default: begin
            w_be    = 4'b1111;
            w_wdata = r_x2;
          end
        endcase
      end
    end
  end

  always_comb begin
    w_byte = 8'h0;
    case (r_res[1:0])
      2'b00: w_byte = dmem_rdata[7:0];
      2'b01: w_byte = dmem_rdata[15:8];
      2'b10: w_byte = dmem_rdata[23:16];
      2'b11: w_byte = dmem_rdata[31:24];
      default: w_byte = 8'h0;
    endcase
    w_half = r_res[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    w_load_data = dmem_rdata;
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_data = {24'h0, w_byte};
      3'b101:  w_load_data = {16'h0, w_half};
      default: w_load_data = dmem_rdata;
    endcase
  end

  // A load only reaches here unstalled on ack or abort; an abort squashes it.
  always_comb begin
    w_wb_rd  = 5'd0;
    w_wb_res = r_res;
    if (r_valid && !w_misaligned) begin
      if (w_is_load) begin
        w_wb_res = w_load_data;
        if (!w_timeout) w_wb_rd = r_rd;
      end else if (!w_is_store && !w_is_branch) begin
        w_wb_rd = r_rd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_valid  <= 1'b0;
      r_opcode <= 7'd0;
      r_funct3 <= 3'd0;
      r_rd     <= 5'd0;
      r_res    <= 32'h0;
      r_x2     <= 32'h0;
    end else if (!stall_MEM) begin
      r_state  <= w_ex_access ? ST_ACCESS : ST_IDLE;
      r_cnt    <= '0;
      r_valid  <= valid_EX;
      r_opcode <= opcode_EX;
      r_funct3 <= funct3_EX;
      r_rd     <= rd_EX;
      r_res    <= res_EX;
      r_x2     <= x2_EX;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // While stalled a bubble enters WB; res_WB keeps its last value.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_WB  <= 5'd0;
      res_WB <= 32'h0;
    end else if (stall_MEM) begin
      rd_WB <= 5'd0;
    end else begin
      rd_WB  <= w_wb_rd;
      res_WB <= w_wb_res;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboarded bench for mem_access_stage: directed ops, queued WB/bus expectations.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_EX;
  logic [6:0]  opcode_EX;
  logic [2:0]  funct3_EX;
  logic [4:0]  rd_EX;
  logic [31:0] res_EX;
  logic [31:0] x2_EX;
  logic        stall_MEM;
  logic [4:0]  rd_MEM;
  logic [31:0] res_MEM;
  logic [4:0]  rd_WB;
  logic [31:0] res_WB;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        misalign_err;
  logic        bus_err;

  always #5 clk = ~clk;

  mem_access_stage #(.ACK_TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .valid_EX(valid_EX), .opcode_EX(opcode_EX),
    .funct3_EX(funct3_EX), .rd_EX(rd_EX), .res_EX(res_EX), .x2_EX(x2_EX),
    .stall_MEM(stall_MEM), .rd_MEM(rd_MEM), .res_MEM(res_MEM),
    .rd_WB(rd_WB), .res_WB(res_WB), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .misalign_err(misalign_err), .bus_err(bus_err)
  );

  localparam logic [6:0] OP_ALU   = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] res;
  } wb_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  wb_t  wb_q[$];
  bus_t bus_q[$];

  int n_chk = 0;
  int n_pass = 0;
  int stall_cnt = 0;
  int mis_cnt = 0;
  int berr_cnt = 0;
  int req_cnt = 0;
  int ack_delay = 1;
  int rsp_cnt = 0;
  logic [31:0] mem_rdata = 32'h0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Memory responder: acks in the ack_delay-th request cycle (0 = never).
  initial begin
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      dmem_ack   = dmem_req && (ack_delay != 0) && (rsp_cnt + 1 == ack_delay);
      dmem_rdata = dmem_ack ? mem_rdata : 32'hA5A5_A5A5;
      @(negedge clk);
      if (reset || !dmem_req || dmem_ack || bus_err) rsp_cnt = 0;
      else rsp_cnt = rsp_cnt + 1;
    end
  end

  // Monitor: pops expectations whenever WB writes or a bus access completes.
  always @(negedge clk) begin
    if (!reset) begin
      stall_cnt += int'(stall_MEM);
      mis_cnt   += int'(misalign_err);
      berr_cnt  += int'(bus_err);
      req_cnt   += int'(dmem_req);
      if (rd_WB != 5'd0) begin
        if (wb_q.size() == 0) begin
          n_chk++;
          $display("FAIL wb_unexpected: got rd %0d res %h expected no write", rd_WB, res_WB);
        end else begin
          wb_t e;
          e = wb_q.pop_front();
          check32("wb_rd", 32'(rd_WB), 32'(e.rd));
          check32("wb_res", res_WB, e.res);
        end
      end
      if (dmem_req && dmem_ack) begin
        if (bus_q.size() == 0) begin
          n_chk++;
          $display("FAIL bus_unexpected: got addr %h expected no access", dmem_addr);
        end else begin
          bus_t b;
          b = bus_q.pop_front();
          check32("bus_we", 32'(dmem_we), 32'(b.we));
          check32("bus_addr", dmem_addr, b.addr);
          check32("bus_be", 32'(dmem_be), 32'(b.be));
          if (b.we) check32("bus_wdata", dmem_wdata, b.wdata);
        end
      end
    end
  end

  // Drives one EX op and returns #1 after the edge that captures it into MEM.
  task automatic send(input logic v, input logic [6:0] op, input logic [2:0] f3,
                      input logic [4:0] rd, input logic [31:0] res, input logic [31:0] x2);
    valid_EX  = v;
    opcode_EX = op;
    funct3_EX = f3;
    rd_EX     = rd;
    res_EX    = res;
    x2_EX     = x2;
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      if (!stall_MEM) break;
      if (k == 40) begin
        n_chk++;
        $display("FAIL stall_bound: got stall_MEM still 1 expected release within 40 cycles");
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    send(1'b0, 7'd0, 3'd0, 5'd0, 32'h0, 32'h0);
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] res);
    wb_t e;
    e.rd = rd; e.res = res;
    if (rd != 5'd0) wb_q.push_back(e);
    send(1'b1, OP_ALU, 3'd0, rd, res, 32'h0);
  endtask

  task automatic load(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] addr,
                      input logic [31:0] data, input int delay, input logic [31:0] exp);
    wb_t  e;
    bus_t b;
    ack_delay = delay;
    mem_rdata = data;
    b.we = 1'b0; b.addr = {addr[31:2], 2'b00}; b.be = 4'hF; b.wdata = 32'h0;
    bus_q.push_back(b);
    e.rd = rd; e.res = exp;
    if (rd != 5'd0) wb_q.push_back(e);
    send(1'b1, OP_LOAD, f3, rd, addr, 32'h0);
  endtask

  task automatic store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] x2,
                       input int delay, input logic [3:0] be, input logic [31:0] wdata);
    bus_t b;
    ack_delay = delay;
    b.we = 1'b1; b.addr = {addr[31:2], 2'b00}; b.be = be; b.wdata = wdata;
    bus_q.push_back(b);
    send(1'b1, OP_STORE, f3, 5'd3, addr, x2);
  endtask

  int s0, m0, e0, r0;

  task automatic snap();
    s0 = stall_cnt; m0 = mis_cnt; e0 = berr_cnt; r0 = req_cnt;
  endtask

  initial begin
    reset = 1'b1;
    valid_EX = 1'b0; opcode_EX = 7'd0; funct3_EX = 3'd0;
    rd_EX = 5'd0; res_EX = 32'h0; x2_EX = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check32("rst_stall", 32'(stall_MEM), 32'd0);
    check32("rst_req", 32'(dmem_req), 32'd0);
    check32("rst_rd_mem", 32'(rd_MEM), 32'd0);
    check32("rst_res_mem", res_MEM, 32'h0);
    check32("rst_rd_wb", 32'(rd_WB), 32'd0);
    check32("rst_res_wb", res_WB, 32'h0);
    check32("rst_errs", {30'd0, misalign_err, bus_err}, 32'd0);
    reset = 1'b0;
    bubble();

    // ALU pass-through and forwarding tap
    snap();
    alu(5'd5, 32'h0000_002A);
    check32("add_rd_mem", 32'(rd_MEM), 32'd5);
    check32("add_res_mem", res_MEM, 32'h2A);
    bubble();
    bubble();
    check32("add_no_stall", 32'(stall_cnt - s0), 32'd0);

    // Byte/half loads with sign and zero extension
    snap();
    load(3'b000, 5'd3, 32'h0000_0103, 32'h80FF_1234, 3, 32'hFFFF_FF80);
    check32("lb_rd_mem", 32'(rd_MEM), 32'd0);
    check32("lb_req", 32'(dmem_req), 32'd1);
    bubble();
    check32("lb_stall", 32'(stall_cnt - s0), 32'd2);
    load(3'b100, 5'd4, 32'h0000_0103, 32'h80FF_1234, 1, 32'h0000_0080);
    bubble();
    load(3'b001, 5'd6, 32'h0000_0102, 32'h80FF_1234, 1, 32'hFFFF_80FF);
    bubble();
    load(3'b101, 5'd8, 32'h0000_0100, 32'h80FF_1234, 2, 32'h0000_1234);
    bubble();
    load(3'b010, 5'd0, 32'h0000_0108, 32'h1111_2222, 1, 32'h0);
    bubble();

    // Stores: lane enables and replicated data
    snap();
    store(3'b001, 32'h0000_0202, 32'hDEAD_BEEF, 1, 4'b1100, 32'hBEEF_BEEF);
    check32("sh_we", 32'(dmem_we), 32'd1);
    bubble();
    check32("sh_no_stall", 32'(stall_cnt - s0), 32'd0);
    store(3'b000, 32'h0000_0201, 32'h1234_5678, 1, 4'b0010, 32'h7878_7878);
    bubble();
    snap();
    store(3'b010, 32'h0000_0204, 32'hA1B2_C3D4, 2, 4'b1111, 32'hA1B2_C3D4);
    bubble();
    check32("sw_stall", 32'(stall_cnt - s0), 32'd1);

    // Misaligned word load is squashed without a request
    snap();
    send(1'b1, OP_LOAD, 3'b010, 5'd12, 32'h0000_0301, 32'h0);
    check32("mis_pulse", 32'(misalign_err), 32'd1);
    check32("mis_no_req", 32'(dmem_req), 32'd0);
    alu(5'd13, 32'h0000_0777);
    check32("mis_rd_wb", 32'(rd_WB), 32'd0);
    bubble();
    check32("mis_count", 32'(mis_cnt - m0), 32'd1);
    check32("mis_req_count", 32'(req_cnt - r0), 32'd0);
    check32("mis_no_stall", 32'(stall_cnt - s0), 32'd0);

    // Timeout with no ack
    snap();
    ack_delay = 0;
    send(1'b1, OP_LOAD, 3'b010, 5'd10, 32'h0000_0400, 32'h0);
    bubble();
    check32("to_req_drop", 32'(dmem_req), 32'd0);
    check32("to_rd_wb", 32'(rd_WB), 32'd0);
    check32("to_berr", 32'(berr_cnt - e0), 32'd1);
    check32("to_stall", 32'(stall_cnt - s0), 32'd15);
    check32("to_req_cycles", 32'(req_cnt - r0), 32'd16);
    bubble();

    // Ack in the last allowed cycle wins over the timeout
    snap();
    load(3'b010, 5'd11, 32'h0000_0400, 32'hCAFE_F00D, 16, 32'hCAFE_F00D);
    bubble();
    check32("late_ack_berr", 32'(berr_cnt - e0), 32'd0);
    check32("late_ack_stall", 32'(stall_cnt - s0), 32'd15);
    bubble();

    // Reset in the second wait cycle abandons the access
    snap();
    ack_delay = 0;
    send(1'b1, OP_LOAD, 3'b010, 5'd9, 32'h0000_0500, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    valid_EX = 1'b0;
    @(posedge clk);
    #1;
    check32("mr_req", 32'(dmem_req), 32'd0);
    check32("mr_stall", 32'(stall_MEM), 32'd0);
    check32("mr_rd_wb", 32'(rd_WB), 32'd0);
    check32("mr_res_wb", res_WB, 32'h0);
    check32("mr_fwd", {22'd0, rd_MEM, 5'd0} | res_MEM, 32'h0);
    check32("mr_be", 32'(dmem_be), 32'd0);
    reset = 1'b0;
    alu(5'd7, 32'h0000_0015);
    bubble();
    bubble();
    check32("mr_berr", 32'(berr_cnt - e0), 32'd0);

    repeat (2) @(posedge clk);
    #1;
    check32("wb_q_drained", 32'(wb_q.size()), 32'd0);
    check32("bus_q_drained", 32'(bus_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
